// File: rtl/fsm_rd_pkg.sv
// Shared types and constants for the axs_s0 read-side control FSM.
package fsm_rd_pkg;

  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    ERR
  } rdState_e;

endpackage

// File: rtl/fsm_rd_wait_tmr.sv
// Saturating empty-FIFO wait counter; flags expiry one cycle before TIMEOUT_CYC waits elapse.
module fsm_rd_wait_tmr #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMR_W       = 11
) (
  input  logic clock_clk,
  input  logic reset_reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  // A zero timeout disables expiry entirely, so the compare value is irrelevant then.
  localparam logic [TMR_W-1:0] EXP_VAL = (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT_CYC != 0) && (count_q == EXP_VAL);

endmodule

// File: rtl/fsm_rd_0.sv
// Read-side control FSM for AXI4 slave port axs_s0: AR accept, FIFO pops, R handshakes.
module fsm_rd_0
  import fsm_rd_pkg::*;
#(
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMR_W       = 11
) (
  input  logic             clock_clk,
  input  logic             reset_reset,
  input  logic             axs_s0_arvalid,
  output logic             axs_s0_arready,
  input  logic [LEN_W-1:0] axs_s0_arlen,
  output logic             axs_s0_rvalid,
  input  logic             axs_s0_rready,
  output logic             axs_s0_rlast,
  output logic [1:0]       axs_s0_rresp,
  input  logic             out_fifo_empty,
  output logic             out_fifo_pop,
  output logic             out_fifo_clr,
  output logic             arid_reg_ld,
  output logic             araddr_reg_ld,
  output logic             arsize_reg_ld,
  output logic             arburst_reg_ld,
  output logic             arid_reg_clr,
  output logic             araddr_reg_clr,
  output logic             arsize_reg_clr,
  output logic             arburst_reg_clr,
  output logic             rdata_reg_ld,
  output logic             rdata_reg_clr
);

  rdState_e         state_q, state_d;
  logic [LEN_W-1:0] beatCnt_q, beatCnt_d;
  logic             tmrClr, tmrInc, tmrExpired;
  logic             arLd, arClr;
  logic             lastBeat;

  assign lastBeat = (beatCnt_q == '0);

  fsm_rd_wait_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_wait_tmr (
    .clock_clk  (clock_clk),
    .reset_reset(reset_reset),
    .clr_i      (tmrClr),
    .inc_i      (tmrInc),
    .expired_o  (tmrExpired)
  );

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    beatCnt_d      = beatCnt_q;
    tmrClr         = 1'b0;
    tmrInc         = 1'b0;
    axs_s0_arready = 1'b0;
    axs_s0_rvalid  = 1'b0;
    axs_s0_rlast   = 1'b0;
    axs_s0_rresp   = RESP_OKAY;
    out_fifo_pop   = 1'b0;
    out_fifo_clr   = 1'b0;
    rdata_reg_ld   = 1'b0;
    rdata_reg_clr  = 1'b0;
    arLd           = 1'b0;
    arClr          = 1'b0;

    case (state_q)
      IDLE: begin
        axs_s0_arready = 1'b1;
        if (axs_s0_arvalid) begin
          arLd      = 1'b1;
          beatCnt_d = axs_s0_arlen;
          tmrClr    = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (!out_fifo_empty) begin
          out_fifo_pop = 1'b1;
          rdata_reg_ld = 1'b1;
          state_d      = DATA;
        end else begin
          tmrInc = 1'b1;
          if (tmrExpired) begin
            rdata_reg_clr = 1'b1;
            state_d       = ERR;
          end
        end
      end
      DATA: begin
        axs_s0_rvalid = 1'b1;
        axs_s0_rlast  = lastBeat;
        if (axs_s0_rready) begin
          if (lastBeat) begin
            state_d = IDLE;
          end else begin
            beatCnt_d = beatCnt_q - 1'b1;
            tmrClr    = 1'b1;
            // Next word already waiting: pop now so the following beat has no bubble.
            if (!out_fifo_empty) begin
              out_fifo_pop = 1'b1;
              rdata_reg_ld = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      ERR: begin
        axs_s0_rvalid = 1'b1;
        axs_s0_rresp  = RESP_SLVERR;
        axs_s0_rlast  = lastBeat;
        rdata_reg_clr = 1'b1;
        if (axs_s0_rready) begin
          if (lastBeat) begin
            state_d = IDLE;
          end else begin
            beatCnt_d = beatCnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is held every strobe is forced quiet except the clears.
    if (reset_reset) begin
      axs_s0_arready = 1'b0;
      axs_s0_rvalid  = 1'b0;
      axs_s0_rlast   = 1'b0;
      axs_s0_rresp   = RESP_OKAY;
      out_fifo_pop   = 1'b0;
      rdata_reg_ld   = 1'b0;
      arLd           = 1'b0;
      out_fifo_clr   = 1'b1;
      rdata_reg_clr  = 1'b1;
      arClr          = 1'b1;
    end
  end

  assign arid_reg_ld     = arLd;
  assign araddr_reg_ld   = arLd;
  assign arsize_reg_ld   = arLd;
  assign arburst_reg_ld  = arLd;
  assign arid_reg_clr    = arClr;
  assign araddr_reg_clr  = arClr;
  assign arsize_reg_clr  = arClr;
  assign arburst_reg_clr = arClr;

endmodule

// File: tb/tb_fsm_rd_0.sv
// Directed self-checking bench for fsm_rd_0 with a counting model of the output FIFO.
module tb_fsm_rd_0;

  localparam int LEN_W       = 8;
  localparam int TIMEOUT_CYC = 8;
  localparam int TMR_W       = 11;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             arvalid = 1'b0;
  logic [LEN_W-1:0] arlen   = '0;
  logic             rready  = 1'b0;
  logic             arready, rvalid, rlast;
  logic [1:0]       rresp;
  logic             fifoEmpty, fifoPop, fifoClr;
  logic             aridLd, araddrLd, arsizeLd, arburstLd;
  logic             aridClr, araddrClr, arsizeClr, arburstClr;
  logic             rdLd, rdClr;

  int   pushCnt   = 0;
  int   popCnt    = 0;
  int   popTotal  = 0;
  logic underflow = 1'b0;
  int   checkCnt  = 0;
  int   passCnt   = 0;
  int   failCnt   = 0;
  int   p0;

  fsm_rd_0 #(
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) dut (
    .clock_clk      (clk),
    .reset_reset    (reset),
    .axs_s0_arvalid (arvalid),
    .axs_s0_arready (arready),
    .axs_s0_arlen   (arlen),
    .axs_s0_rvalid  (rvalid),
    .axs_s0_rready  (rready),
    .axs_s0_rlast   (rlast),
    .axs_s0_rresp   (rresp),
    .out_fifo_empty (fifoEmpty),
    .out_fifo_pop   (fifoPop),
    .out_fifo_clr   (fifoClr),
    .arid_reg_ld    (aridLd),
    .araddr_reg_ld  (araddrLd),
    .arsize_reg_ld  (arsizeLd),
    .arburst_reg_ld (arburstLd),
    .arid_reg_clr   (aridClr),
    .araddr_reg_clr (araddrClr),
    .arsize_reg_clr (arsizeClr),
    .arburst_reg_clr(arburstClr),
    .rdata_reg_ld   (rdLd),
    .rdata_reg_clr  (rdClr)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (pushCnt == popCnt);

  // FIFO occupancy model: pushes come from the stimulus, pops and flushes from the DUT.
  always @(posedge clk) begin
    if (fifoClr) begin
      popCnt <= pushCnt;
    end else if (fifoPop) begin
      if (pushCnt == popCnt) underflow <= 1'b1;
      popCnt   <= popCnt + 1;
      popTotal <= popTotal + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [LEN_W-1:0] len, input logic rr);
    arvalid = av;
    arlen   = len;
    rready  = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("rst_arid_clr",    32'(aridClr),    1);
    checkOutput("rst_araddr_clr",  32'(araddrClr),  1);
    checkOutput("rst_arsize_clr",  32'(arsizeClr),  1);
    checkOutput("rst_arburst_clr", 32'(arburstClr), 1);
    checkOutput("rst_rdata_clr",   32'(rdClr),      1);
    checkOutput("rst_fifo_clr",    32'(fifoClr),    1);
    checkOutput("rst_arready",     32'(arready),    0);
    checkOutput("rst_rvalid",      32'(rvalid),     0);
    tick();
    tick();
    reset = 1'b0;

    // 1: arlen=3 with 4 words ready, back-to-back beats
    pushCnt = pushCnt + 4;
    p0 = popTotal;
    applyStimulus(1'b1, 8'd3, 1'b1);
    checkOutput("t1_arready",    32'(arready),   1);
    checkOutput("t1_arid_ld",    32'(aridLd),    1);
    checkOutput("t1_araddr_ld",  32'(araddrLd),  1);
    checkOutput("t1_arsize_ld",  32'(arsizeLd),  1);
    checkOutput("t1_arburst_ld", 32'(arburstLd), 1);
    checkOutput("t1_fifo_clr",   32'(fifoClr),   0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("t1_fetch_rvalid", 32'(rvalid),  0);
    checkOutput("t1_fetch_arrdy",  32'(arready), 0);
    checkOutput("t1_fetch_pop",    32'(fifoPop), 1);
    checkOutput("t1_fetch_ld",     32'(rdLd),    1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("t1_rvalid", 32'(rvalid),  1);
      checkOutput("t1_rlast",  32'(rlast),   32'(i == 3));
      checkOutput("t1_rresp",  32'(rresp),   0);
      checkOutput("t1_pop",    32'(fifoPop), 32'(i != 3));
      checkOutput("t1_arrdy",  32'(arready), 0);
      tick();
    end
    #1;
    checkOutput("t1_idle_arrdy",  32'(arready),       1);
    checkOutput("t1_idle_rvalid", 32'(rvalid),        0);
    checkOutput("t1_pops",        32'(popTotal - p0), 4);

    // 2: arlen=0, FIFO empty for 5 cycles then a single word
    p0 = popTotal;
    applyStimulus(1'b1, 8'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_wait_rvalid", 32'(rvalid),  0);
      checkOutput("t2_wait_pop",    32'(fifoPop), 0);
      tick();
    end
    pushCnt = pushCnt + 1;
    #1;
    checkOutput("t2_pop", 32'(fifoPop), 1);
    tick();
    #1;
    checkOutput("t2_rvalid", 32'(rvalid), 1);
    checkOutput("t2_rlast",  32'(rlast),  1);
    checkOutput("t2_rresp",  32'(rresp),  0);
    tick();
    #1;
    checkOutput("t2_idle_arrdy", 32'(arready),       1);
    checkOutput("t2_pops",       32'(popTotal - p0), 1);

    // 3: arlen=1, rready held low for 3 cycles on beat 1
    pushCnt = pushCnt + 2;
    p0 = popTotal;
    applyStimulus(1'b1, 8'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("t3_fetch_pop", 32'(fifoPop), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t3_hold_rvalid", 32'(rvalid),  1);
      checkOutput("t3_hold_rlast",  32'(rlast),   0);
      checkOutput("t3_hold_rresp",  32'(rresp),   0);
      checkOutput("t3_hold_pop",    32'(fifoPop), 0);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("t3_hs_pop",   32'(fifoPop), 1);
    checkOutput("t3_hs_rlast", 32'(rlast),   0);
    tick();
    #1;
    checkOutput("t3_b2_rlast", 32'(rlast),   1);
    checkOutput("t3_b2_pop",   32'(fifoPop), 0);
    tick();
    #1;
    checkOutput("t3_idle_arrdy", 32'(arready),       1);
    checkOutput("t3_pops",       32'(popTotal - p0), 2);

    // 4: arlen=2, FIFO never fills, 8-cycle timeout then SLVERR beats
    p0 = popTotal;
    applyStimulus(1'b1, 8'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      checkOutput("t4_wait_rvalid", 32'(rvalid), 0);
      checkOutput("t4_wait_clr",    32'(rdClr),  0);
      tick();
      #1;
    end
    checkOutput("t4_expire_clr",    32'(rdClr),  1);
    checkOutput("t4_expire_rvalid", 32'(rvalid), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4_err_rvalid", 32'(rvalid),  1);
      checkOutput("t4_err_rresp",  32'(rresp),   2);
      checkOutput("t4_err_clr",    32'(rdClr),   1);
      checkOutput("t4_err_pop",    32'(fifoPop), 0);
      checkOutput("t4_err_rlast",  32'(rlast),   32'(i == 2));
      tick();
    end
    #1;
    checkOutput("t4_idle_arrdy",  32'(arready),       1);
    checkOutput("t4_idle_rvalid", 32'(rvalid),        0);
    checkOutput("t4_pops",        32'(popTotal - p0), 0);

    // 5: reset during beat 2 of a 4-beat burst, then a fresh burst
    pushCnt = pushCnt + 4;
    applyStimulus(1'b1, 8'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    tick();
    #1;
    checkOutput("t5_b2_rvalid", 32'(rvalid), 1);
    checkOutput("t5_b2_rlast",  32'(rlast),  0);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_pop",    32'(fifoPop), 0);
    checkOutput("t5_rst_rvalid", 32'(rvalid),  0);
    tick();
    #1;
    checkOutput("t5_rst_clr",    32'(rdClr),   1);
    checkOutput("t5_rst_arclr",  32'(aridClr), 1);
    checkOutput("t5_rst_fclr",   32'(fifoClr), 1);
    checkOutput("t5_rst_rvalid2", 32'(rvalid), 0);
    checkOutput("t5_rst_rlast",  32'(rlast),   0);
    checkOutput("t5_rst_arrdy",  32'(arready), 0);
    reset = 1'b0;
    #1;
    checkOutput("t5_rel_arrdy", 32'(arready), 1);
    checkOutput("t5_rel_clr",   32'(rdClr),   0);
    checkOutput("t5_fifo_flush", 32'(fifoEmpty), 1);
    pushCnt = pushCnt + 2;
    p0 = popTotal;
    applyStimulus(1'b1, 8'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("t5_new_fetch_pop", 32'(fifoPop), 1);
    tick();
    #1;
    checkOutput("t5_new_b1_rvalid", 32'(rvalid), 1);
    checkOutput("t5_new_b1_rlast",  32'(rlast),  0);
    tick();
    #1;
    checkOutput("t5_new_b2_rlast", 32'(rlast), 1);
    checkOutput("t5_new_b2_rresp", 32'(rresp), 0);
    tick();
    #1;
    checkOutput("t5_new_idle", 32'(arready),       1);
    checkOutput("t5_new_pops", 32'(popTotal - p0), 2);

    // 6: arvalid held across a burst end
    pushCnt = pushCnt + 1;
    applyStimulus(1'b1, 8'd0, 1'b1);
    checkOutput("t6_ar1", 32'(arready), 1);
    tick();
    #1;
    checkOutput("t6_fetch_arrdy", 32'(arready), 0);
    tick();
    #1;
    checkOutput("t6_hs_rlast", 32'(rlast),   1);
    checkOutput("t6_hs_arrdy", 32'(arready), 0);
    tick();
    #1;
    checkOutput("t6_ar2_arrdy", 32'(arready), 1);
    checkOutput("t6_ar2_ld",    32'(aridLd),  1);
    pushCnt = pushCnt + 1;
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("t6_ar2_pop", 32'(fifoPop), 1);
    tick();
    #1;
    checkOutput("t6_ar2_rlast", 32'(rlast), 1);
    tick();
    #1;
    checkOutput("t6_end_arrdy", 32'(arready),   1);
    checkOutput("t6_underflow", 32'(underflow), 0);

    if (failCnt != 0) $display("[TB] %0d comparisons disagreed", failCnt);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
